// File: rtl/cdec_loader_pkg.sv
// Shared types and constants for the CDEC serial program loader.
package cdec_loader_pkg;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_RUN
  } frame_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/cdec_uart_rx.sv
// 8N1 receiver: 2-FF synchronizer, mid-bit sampling down-counter timer and shift register.
// Emits one-cycle byte_valid or frame_err pulses at the stop-bit sample.
module cdec_uart_rx
  import cdec_loader_pkg::*;
#(
  parameter int BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] FULL = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] HALF = TW'(BAUD_DIV / 2 - 1);

  logic            sync1, sync2, prev;
  rx_state_t       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            timer_zero;

  assign timer_zero = (timer_q == '0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev && !sync2) begin
          state_d = RX_START;
          timer_d = HALF;
        end
      end
      RX_START: begin
        if (!timer_zero) begin
          timer_d = timer_q - TW'(1);
        end else if (!sync2) begin
          state_d   = RX_DATA;
          timer_d   = FULL;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = RX_IDLE;  // start bit did not hold: glitch
        end
      end
      RX_DATA: begin
        if (!timer_zero) begin
          timer_d = timer_q - TW'(1);
        end else begin
          shift_d   = {sync2, shift_q[7:1]};
          timer_d   = FULL;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (!timer_zero) begin
          timer_d = timer_q - TW'(1);
        end else begin
          valid_d = sync2;
          ferr_d  = !sync2;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      prev      <= 1'b1;
      state_q   <= RX_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1     <= rxd;
      sync2     <= sync1;
      prev      <= sync2;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_byte    = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/cdec_loader.sv
// Serial program loader for the CDEC core RAM; holds the core in reset until a frame loads.
// Optional checksum byte enabled by defining CDEC_LOADER_CHKSUM_EN.
module cdec_loader
  import cdec_loader_pkg::*;
#(
  parameter int         BAUD_DIV  = 104,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic       iClkMst,
  input  logic       iReset,
  input  logic       iRxd,
  output logic [7:0] oRamAddr,
  output logic [7:0] oRamData,
  output logic       oRamWe,
  output logic       oCoreReset,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError
);

  logic [7:0]   rx_byte;
  logic         byte_valid, frame_err;
  frame_state_t state_q, state_d;
  logic [7:0]   addr_q, addr_d;
  logic [8:0]   count_q, count_d;
  logic [7:0]   ram_addr_d, ram_data_d;
  logic         ram_we_d, core_reset_d, done_d, error_d;
`ifdef CDEC_LOADER_CHKSUM_EN
  logic [7:0]   sum_q, sum_d, chk_total;
  assign chk_total = sum_q + rx_byte;
`endif

  cdec_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk       (iClkMst),
    .reset     (iReset),
    .rxd       (iRxd),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    ram_addr_d   = oRamAddr;
    ram_data_d   = oRamData;
    ram_we_d     = 1'b0;
    core_reset_d = oCoreReset;
    done_d       = oDone;
    error_d      = oError;
`ifdef CDEC_LOADER_CHKSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      ST_SYNC, ST_RUN: begin
        if (byte_valid && rx_byte == SYNC_BYTE) begin
          state_d      = ST_LEN;
          core_reset_d = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
        end
      end
      ST_LEN: begin
        if (byte_valid) begin
          count_d = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
          addr_d  = 8'h00;
`ifdef CDEC_LOADER_CHKSUM_EN
          sum_d   = 8'h00;
`endif
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (byte_valid) begin
          ram_we_d   = 1'b1;
          ram_addr_d = addr_q;
          ram_data_d = rx_byte;
          addr_d     = addr_q + 8'd1;
          count_d    = count_q - 9'd1;
`ifdef CDEC_LOADER_CHKSUM_EN
          sum_d      = sum_q + rx_byte;
          if (count_q == 9'd1) state_d = ST_CHK;
`else
          if (count_q == 9'd1) begin
            state_d      = ST_RUN;
            done_d       = 1'b1;
            core_reset_d = 1'b0;
          end
`endif
        end
      end
`ifdef CDEC_LOADER_CHKSUM_EN
      ST_CHK: begin
        if (byte_valid) begin
          if (chk_total == 8'h00) begin
            state_d      = ST_RUN;
            done_d       = 1'b1;
            core_reset_d = 1'b0;
          end else begin
            state_d = ST_SYNC;
            error_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_SYNC;
    endcase
    // A broken byte aborts any frame in progress; the core stays held.
    if (frame_err && (state_q == ST_LEN || state_q == ST_DATA || state_q == ST_CHK)) begin
      state_d = ST_SYNC;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge iClkMst) begin
    if (iReset) begin
      state_q    <= ST_SYNC;
      addr_q     <= 8'h00;
      count_q    <= 9'd0;
      oRamAddr   <= 8'h00;
      oRamData   <= 8'h00;
      oRamWe     <= 1'b0;
      oCoreReset <= 1'b1;
      oDone      <= 1'b0;
      oError     <= 1'b0;
`ifdef CDEC_LOADER_CHKSUM_EN
      sum_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      oRamAddr   <= ram_addr_d;
      oRamData   <= ram_data_d;
      oRamWe     <= ram_we_d;
      oCoreReset <= core_reset_d;
      oDone      <= done_d;
      oError     <= error_d;
`ifdef CDEC_LOADER_CHKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign oBusy = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);

endmodule

// File: tb/tb_cdec_loader.sv
// Self-checking bench for cdec_loader: frame-level reference model with randomized frames.
module tb_cdec_loader;

  localparam int BAUD = 4;
`ifdef CDEC_LOADER_CHKSUM_EN
  localparam bit HAS_CHK = 1'b1;
`else
  localparam bit HAS_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] ram_addr, ram_data;
  logic       ram_we, core_reset, busy, done, error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         start_log[$];
  int         we_wide = 0;
  logic       we_prev = 1'b0;
  logic       core_prev = 1'b1;
  int         fall_cyc = 0;
  int         rise_cyc = 0;

  cdec_loader #(.BAUD_DIV(BAUD), .SYNC_BYTE(8'hA5)) dut (
    .iClkMst   (clk),
    .iReset    (rst),
    .iRxd      (rxd),
    .oRamAddr  (ram_addr),
    .oRamData  (ram_data),
    .oRamWe    (ram_we),
    .oCoreReset(core_reset),
    .oBusy     (busy),
    .oDone     (done),
    .oError    (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wr_addr_q.push_back(ram_addr);
      wr_data_q.push_back(ram_data);
      if (we_prev === 1'b1) we_wide++;
    end
    we_prev = ram_we;
    if (core_prev === 1'b1 && core_reset === 1'b0) fall_cyc = cyc;
    if (core_prev === 1'b0 && core_reset === 1'b1) rise_cyc = cyc;
    core_prev = core_reset;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rxd = 1'b0;
    start_log.push_back(cyc);
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(BAUD);
    end
    rxd = stop_ok;
    tick(BAUD);
    rxd = 1'b1;
    if (!stop_ok) tick(3 * BAUD);
  endtask

  task automatic send_frame(input logic [7:0] data[$], input logic [7:0] chk, input bit with_chk);
    send_byte(8'hA5, 1'b1);
    send_byte(8'(data.size()), 1'b1);
    foreach (data[i]) send_byte(data[i], 1'b1);
    if (with_chk) send_byte(chk, 1'b1);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    start_log.delete();
    we_wide = 0;
  endtask

  // Frame verdict from the frame rules: data plus check byte must sum to zero mod 256.
  function automatic bit model_ok(input logic [7:0] data[$], input logic [7:0] chk);
    int s;
    if (!HAS_CHK) return 1'b1;
    s = chk;
    foreach (data[i]) s += data[i];
    return (s % 256) == 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(2);
    checks++; if (ram_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", ram_addr); end
    checks++; if (ram_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", ram_data); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", ram_we); end
    checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL reset_core got=%b exp=1", core_reset); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
  endtask

  task automatic test_basic();
    logic [7:0] d[$];
    bit ok;
    int last_idx, lat;
    d = '{8'h11, 8'h22, 8'h33};
    ok = model_ok(d, 8'h9A);
    clear_log();
    send_frame(d, 8'h9A, 1'b1);
    tick(6);
    checks++; if (wr_addr_q.size() != 3) begin failures++; $display("FAIL basic_wr_count got=%0d exp=3", wr_addr_q.size()); end
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== d[i]) begin
        failures++; $display("FAIL basic_wr%0d got=%h<-%h exp=%h<-%h", i, wr_addr_q[i], wr_data_q[i], 8'(i), d[i]);
      end
    end
    checks++; if (we_wide != 0) begin failures++; $display("FAIL basic_we_width got=%0d exp=0 wide cycles", we_wide); end
    checks++; if (done !== ok) begin failures++; $display("FAIL basic_done got=%b exp=%b", done, ok); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL basic_error got=%b exp=0", error); end
    checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL basic_core got=%b exp=0", core_reset); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", busy); end
    last_idx = HAS_CHK ? 5 : 4;
    lat = fall_cyc - start_log[last_idx];
    checks++; if (lat < 38 || lat > 46) begin failures++; $display("FAIL basic_core_fall_latency got=%0d exp=38..46", lat); end
  endtask

  task automatic test_bad_chk();
    logic [7:0] d[$];
    bit ok;
    d = '{8'h11, 8'h22, 8'h33};
    ok = model_ok(d, 8'h00);
    clear_log();
    send_frame(d, 8'h00, 1'b1);
    tick(6);
    checks++; if (wr_addr_q.size() != 3) begin failures++; $display("FAIL badchk_wr_count got=%0d exp=3", wr_addr_q.size()); end
    checks++; if (done !== ok) begin failures++; $display("FAIL badchk_done got=%b exp=%b", done, ok); end
    checks++; if (error !== !ok) begin failures++; $display("FAIL badchk_error got=%b exp=%b", error, !ok); end
    checks++; if (core_reset !== !ok) begin failures++; $display("FAIL badchk_core got=%b exp=%b", core_reset, !ok); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL badchk_busy got=%b exp=0", busy); end
  endtask

  task automatic test_full_256();
    logic [7:0] d[$];
    int bad;
    bit ok;
    for (int i = 0; i < 256; i++) d.push_back(8'(i));
    ok = model_ok(d, 8'h80);
    clear_log();
    send_frame(d, 8'h80, 1'b1);
    tick(6);
    checks++; if (wr_addr_q.size() != 256) begin failures++; $display("FAIL full_wr_count got=%0d exp=256", wr_addr_q.size()); end
    bad = 0;
    for (int i = 0; i < wr_addr_q.size() && i < 256; i++)
      if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== d[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL full_wr_content got=%0d wrong exp=0", bad); end
    checks++; if (done !== ok) begin failures++; $display("FAIL full_done got=%b exp=%b", done, ok); end
    checks++; if (core_reset !== !ok) begin failures++; $display("FAIL full_core got=%b exp=%b", core_reset, !ok); end
  endtask

  task automatic test_leading_garbage();
    logic [7:0] d[$];
    bit ok;
    d = '{8'h7E};
    ok = model_ok(d, 8'h82);
    clear_log();
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_frame(d, 8'h82, 1'b1);
    tick(6);
    checks++; if (wr_addr_q.size() != 1) begin failures++; $display("FAIL garbage_wr_count got=%0d exp=1", wr_addr_q.size()); end
    checks++; if (wr_addr_q.size() > 0 && (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 8'h7E)) begin
      failures++; $display("FAIL garbage_wr got=%h<-%h exp=00<-7e", wr_addr_q[0], wr_data_q[0]);
    end
    checks++; if (done !== ok) begin failures++; $display("FAIL garbage_done got=%b exp=%b", done, ok); end
  endtask

  task automatic test_reload_and_reset();
    logic [7:0] d[$];
    int lat;
    d = '{8'h7E};
    send_frame(d, 8'h82, 1'b1);
    tick(6);
    checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL reload_pre_core got=%b exp=0", core_reset); end
    clear_log();
    send_byte(8'hA5, 1'b1);
    tick(6);
    lat = rise_cyc - start_log[0];
    checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL reload_core got=%b exp=1", core_reset); end
    checks++; if (lat < 38 || lat > 46) begin failures++; $display("FAIL reload_rise_latency got=%0d exp=38..46", lat); end
    checks++; if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      failures++; $display("FAIL reload_flags got busy=%b done=%b err=%b exp 1 0 0", busy, done, error);
    end
    send_byte(8'h05, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    tick(6);
    checks++; if (wr_addr_q.size() != 2) begin failures++; $display("FAIL middata_wr_count got=%0d exp=2", wr_addr_q.size()); end
    rst = 1'b1;
    tick(1);
    checks++; if (ram_addr !== 8'h00 || ram_data !== 8'h00 || ram_we !== 1'b0) begin
      failures++; $display("FAIL midreset_ram got addr=%h data=%h we=%b exp 00 00 0", ram_addr, ram_data, ram_we);
    end
    checks++; if (core_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      failures++; $display("FAIL midreset_flags got core=%b busy=%b done=%b err=%b exp 1 0 0 0", core_reset, busy, done, error);
    end
    rst = 1'b0;
    tick(2);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h05, 1'b1);
    tick(6);
    checks++; if (wr_addr_q.size() != 2) begin failures++; $display("FAIL postreset_wr_count got=%0d exp=2", wr_addr_q.size()); end
    checks++; if (core_reset !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL postreset_state got core=%b busy=%b exp 1 0", core_reset, busy);
    end
  endtask

  task automatic test_framing_error();
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h9A, 1'b1);
    tick(6);
    checks++; if (wr_addr_q.size() != 1) begin failures++; $display("FAIL ferr_wr_count got=%0d exp=1", wr_addr_q.size()); end
    checks++; if (wr_addr_q.size() > 0 && (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 8'h11)) begin
      failures++; $display("FAIL ferr_wr got=%h<-%h exp=00<-11", wr_addr_q[0], wr_data_q[0]);
    end
    checks++; if (error !== 1'b1 || done !== 1'b0 || core_reset !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL ferr_flags got err=%b done=%b core=%b busy=%b exp 1 0 1 0", error, done, core_reset, busy);
    end
  endtask

  task automatic test_glitch();
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    tick(10);
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(60);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    if (HAS_CHK) send_byte(8'hE3, 1'b1);
    tick(6);
    checks++; if (wr_addr_q.size() != 2) begin failures++; $display("FAIL glitch_wr_count got=%0d exp=2", wr_addr_q.size()); end
    checks++; if (wr_addr_q.size() == 2 && (wr_data_q[0] !== 8'h5A || wr_data_q[1] !== 8'hC3 || wr_addr_q[1] !== 8'h01)) begin
      failures++; $display("FAIL glitch_wr got=%h %h@%h exp=5a c3@01", wr_data_q[0], wr_data_q[1], wr_addr_q[1]);
    end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL glitch_done got done=%b err=%b exp 1 0", done, error); end
    clear_log();
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(60);
    checks++; if (wr_addr_q.size() != 0 || core_reset !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL idle_glitch got writes=%0d core=%b done=%b exp 0 0 1", wr_addr_q.size(), core_reset, done);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 10; f++) begin
      logic [7:0] d[$];
      logic [7:0] chk, g;
      int len, s, bad;
      bit ok;
      len = $urandom_range(1, 16);
      s = 0;
      for (int i = 0; i < len; i++) begin
        d.push_back(8'($urandom_range(0, 255)));
        s += d[i];
      end
      chk = 8'(256 - (s % 256));
      if ($urandom_range(0, 2) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      ok = model_ok(d, chk);
      clear_log();
      g = 8'($urandom_range(0, 255));
      if (g != 8'hA5 && $urandom_range(0, 1) == 1) send_byte(g, 1'b1);
      send_frame(d, chk, HAS_CHK);
      tick(6);
      checks++; if (wr_addr_q.size() != len) begin failures++; $display("FAIL rand%0d_wr_count got=%0d exp=%0d", f, wr_addr_q.size(), len); end
      bad = 0;
      for (int i = 0; i < len && i < wr_addr_q.size(); i++)
        if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== d[i]) bad++;
      checks++; if (bad != 0 || we_wide != 0) begin failures++; $display("FAIL rand%0d_wr_content got=%0d wrong,%0d wide exp=0,0", f, bad, we_wide); end
      checks++; if (done !== ok || error !== !ok || core_reset !== !ok) begin
        failures++; $display("FAIL rand%0d_flags got done=%b err=%b core=%b exp %b %b %b", f, done, error, core_reset, ok, !ok, !ok);
      end
    end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_basic();
    test_bad_chk();
    test_full_256();
    test_leading_garbage();
    test_reload_and_reset();
    test_framing_error();
    test_glitch();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdec_loader.md
# cdec_loader

Serial program loader sitting directly upstream of the CDEC core and its 256×8 RAM. It receives a framed image over an asynchronous 8N1 line and writes it byte-by-byte into the RAM. It holds the core in reset until a load completes (and, if compiled in, its checksum verifies), then releases it. On FPGA it replaces the simulation-time RAM preload.

## Interface
- BAUD_DIV, 104, iClkMst cycles per serial bit; must be ≥ 4.
- SYNC_BYTE, 8'hA5, frame start marker.
- iClkMst  in  1  master clock; all logic on its rising edge.
- iReset  in  1  reset; synchronous, active-high.
- iRxd  in  1  async serial input, idle high, LSB first.
- oRamAddr  out  8  RAM write address.
- oRamData  out  8  RAM write data.
- oRamWe  out  1  RAM write strobe, one-cycle pulse.
- oCoreReset  out  1  reset to CDEC core; high while loading or unloaded.
- oBusy  out  1  frame in progress (states LEN, DATA, CHK).
- oDone  out  1  last load succeeded.
- oError  out  1  last frame failed (framing or checksum).

## Operation
- Frame format: SYNC_BYTE, LEN, LEN data bytes, CHK. LEN = 0 means 256 bytes. CHK makes the 8-bit sum of all data bytes plus CHK equal 8'h00.
- Receiver:
  - 2-FF synchronizer on iRxd.
  - Start detected on a synchronized falling edge.
  - Start bit re-checked low at BAUD_DIV/2. If it reads high, it is a glitch: ignore and go back to idle.
  - 8 data bits sampled at mid-bit, every BAUD_DIV cycles.
  - Stop bit sampled. If high: byte-valid pulse for 1 cycle. If low: framing-error pulse and no byte.
- Frame FSM states:
  - SYNC: wait for SYNC_BYTE; any other byte is ignored.
  - LEN: latch LEN into a 9-bit count (0 → 256). Clear address and sum. Drive oCoreReset=1, oDone=0, oError=0.
  - DATA: each byte → oRamData, oRamAddr = address, oRamWe pulse. Then address += 1 (8-bit, wraps FF→00), sum += byte (mod 256), count -= 1. When count reaches 0 → CHK.
  - CHK: if sum + byte == 0 → RUN with oDone=1; else → SYNC with oError=1.
  - RUN: oCoreReset=0. A new SYNC_BYTE → LEN, which re-asserts core reset for a reload. Other bytes are ignored.
- Framing error in LEN, DATA or CHK → SYNC, oError=1, core stays in reset. RAM keeps any bytes already written.
- Framing error in SYNC or RUN: ignored.
- Reset mid-frame → SYNC. Partial RAM contents are not cleared.
- Reset values: oRamAddr=00, oRamData=00, oRamWe=0, oCoreReset=1, oBusy=0, oDone=0, oError=0. Receiver idle, FSM in SYNC.

## Timing
- Byte-valid pulse occurs at the mid-stop-bit sample: about 9.5×BAUD_DIV + 2 cycles after the start edge on iRxd.
- oRamWe/oRamAddr/oRamData are registered. They are valid in the cycle after byte-valid, for exactly 1 cycle; address and data are held stable afterwards.
- oCoreReset falls 1 cycle after the CHK byte-valid pulse.
- oCoreReset rises 1 cycle after the SYNC_BYTE byte-valid pulse in RUN.
- oDone/oError change in that same cycle.
- A new start bit is accepted from the cycle after the stop-bit sample, so back-to-back bytes with no idle time are supported.

## Configuration
- CDEC_LOADER_CHKSUM_EN defined: CHK byte expected and checked as above.
- Not defined:
  - Frame ends after the last data byte; there is no CHK state.
  - The FSM goes DATA → RUN directly, with oDone=1 one cycle after the final write.
  - oError is set only by framing errors.
  - The sum accumulator is not built.

## Structure
- Package cdec_loader_pkg holds:
  - FSM state enum (SYNC, LEN, DATA, CHK, RUN);
  - default SYNC_BYTE constant;
  - receiver state enum.
- Sub-module cdec_uart_rx (parameter BAUD_DIV) contains the synchronizer, bit timer and shift register. Its outputs are byte, byte-valid pulse and framing-error pulse.
- Top-level cdec_loader contains the frame FSM, address/count/sum registers and output registers.

## Test plan
- BAUD_DIV=4. Send A5 03 11 22 33 9A → writes 00←11, 01←22, 02←33, three single-cycle oRamWe pulses; oDone=1, oError=0, oCoreReset falls.
- Send A5 03 11 22 33 00 (bad CHK) → three writes occur; oError=1, oDone=0, oCoreReset stays 1, FSM in SYNC.
- Send A5 00 followed by bytes 00..FF and CHK 80 → 256 writes, address wraps to 00, oDone=1.
- Send 12 34 then A5 01 7E 82 → leading bytes ignored, one write 00←7E, load succeeds.
- After a successful load, send A5 → oCoreReset rises the cycle after byte-valid; assert iReset mid-DATA → all outputs return to reset values, FSM in SYNC.
- Stop bit driven low on the 2nd data byte → framing error; oError=1, no write for that byte. A 1-cycle low glitch on idle iRxd produces no byte.
